wash_cycle_timer: RTL
=====================

Name: wash_cycle_timer

Overview:
- Plant-side responder to the washing-machine controller. It consumes the controller's one-hot operation commands and generates the completion and time-out status it waits on: sig_Full, sig_Temperature, sig_Wash_Completed, sig_Rinse_Completed, sig_Spin_Completed, sig_Time_Out.
- Used as the appliance model in system simulation and as the phase timer in hardware builds.
- Fill and heat progress are gated by supply/heater health inputs so that fault paths can be exercised.

Parameters:
- FILL_CYCLES, 8, progress cycles needed before sig_Full.
- HEAT_CYCLES, 12, progress cycles needed before sig_Temperature.
- WASH_CYCLES, 16, cycles in wash before sig_Wash_Completed.
- RINSE_CYCLES, 10, cycles in rinse before sig_Rinse_Completed.
- SPIN_CYCLES, 6, cycles in spin before sig_Spin_Completed.
- TIMEOUT_CYCLES, 20, watchdog limit for the fill and heat phases.
- CNT_WIDTH, 16, width of the progress and watchdog counters. All *_CYCLES values must be ≥1 and < 2^CNT_WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- fill_Water_Operation  input  1  fill command.
- heat_Water_Operation  input  1  heat command.
- wash_Operation  input  1  wash command.
- rinse_Operation  input  1  rinse command.
- spin_Operation  input  1  spin command.
- water_Supply_Ok  input  1  fill progress enable.
- heater_Ok  input  1  heat progress enable.
- sig_Full  output  1  fill complete.
- sig_Temperature  output  1  target temperature reached.
- sig_Wash_Completed  output  1  wash complete.
- sig_Rinse_Completed  output  1  rinse complete.
- sig_Spin_Completed  output  1  spin complete.
- sig_Time_Out  output  1  fill/heat watchdog expired.
- cmd_Error  output  1  more than one command asserted.
- phase  output  3  current phase code.

Behaviour:
- Reset (reset_n low, asynchronous): phase=IDLE, progress count=0, watchdog=0, all outputs 0. After reset_n rises, commands are sampled from the next rising edge.
- Phase register, updated every rising edge from the sampled commands:
  - No command asserted → IDLE (code 0).
  - Exactly one asserted → FILL (2), HEAT (3), WASH (4), RINSE (5) or SPIN (6).
  - Two or more asserted → ERR (7).
- Phase codes equal the controller's state codes for the same operation.
- Counter clearing: on any edge where the phase value changes, both progress count and watchdog load 0. This includes direct transitions such as FILL→HEAT and ERR→any phase.
- Progress count, on edges where the phase is unchanged:
  - Increments by 1, saturating at the phase target.
  - FILL increments only if water_Supply_Ok=1.
  - HEAT increments only if heater_Ok=1.
  - WASH, RINSE and SPIN increment unconditionally.
  - IDLE and ERR hold 0.
- Watchdog: in FILL/HEAT with the phase unchanged, increments every edge regardless of the ok inputs, saturating at TIMEOUT_CYCLES. Holds 0 in all other phases.
- Outputs are decoded from registered state only (no combinational path from inputs):
  - sig_Full = (phase==FILL && count==FILL_CYCLES).
  - sig_Temperature, sig_Wash_Completed, sig_Rinse_Completed and sig_Spin_Completed are decoded the same way for their own phase and target.
  - sig_Time_Out = phase∈{FILL,HEAT} && watchdog==TIMEOUT_CYCLES && that phase's completion output is 0. Completion wins over time-out when both would assert.
  - cmd_Error = (phase==ERR).
- Latency: command first sampled high at edge E0 → phase valid after E0 with count 0. With progress enabled every cycle, the completion output rises after edge E0+N (N = phase target).
- Completion and time-out outputs are levels. They hold while the command stays asserted and drop the cycle after the phase changes. Time-out therefore stays high until the controller leaves FILL/HEAT.
- Command deasserted for a single cycle → IDLE for that cycle. Re-entry restarts from 0; there is no resume.
- Reset mid-phase: counters and outputs clear immediately. Re-entry after release counts from 0.

Test Plan:
- Reset, then hold fill_Water_Operation=1 with water_Supply_Ok=1 (FILL_CYCLES=8) → phase=2 after E0, sig_Full rises after E8 and holds; sig_Time_Out stays 0.
- Fill with water_Supply_Ok=0 throughout (TIMEOUT_CYCLES=20) → sig_Full never asserts, sig_Time_Out rises after E20. Dropping fill clears it the next cycle.
- Heat with heater_Ok toggling 1,0,1,0… (HEAT_CYCLES=12) → sig_Temperature after E23 (12 progress edges among 23), and no time-out at 20 is allowed only if the target is reached first. Adjust TIMEOUT_CYCLES=30 and check completion with sig_Time_Out=0.
- Full sequence fill→heat→wash→rinse→spin, each command switched the cycle after its completion → each completion asserts at its exact target, counters restart at every transition, phase codes step 2,3,4,5,6,0.
- wash_Operation=1 and rinse_Operation=1 simultaneously → phase=7, cmd_Error=1, all completion outputs 0. Return to wash alone → count restarts; sig_Wash_Completed after 16 edges.
- Assert reset_n=0 mid-spin at count 3 → all outputs 0 immediately. Release with spin held → sig_Spin_Completed after 6 further progress edges past re-entry.

Source files
------------

// File: rtl/wash_cycle_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : wash_cycle_timer_if
// Description : Command/status bundle between the washing-machine controller
//               and the plant-side wash cycle timer.
// Revision    : 1.0 - initial release
// ============================================================================
interface wash_cycle_timer_if;
  // one-hot operation commands from the controller
  logic       fill_Water_Operation;
  logic       heat_Water_Operation;
  logic       wash_Operation;
  logic       rinse_Operation;
  logic       spin_Operation;
  // plant health inputs gating fill/heat progress
  logic       water_Supply_Ok;
  logic       heater_Ok;
  // status returned to the controller
  logic       sig_Full;
  logic       sig_Temperature;
  logic       sig_Wash_Completed;
  logic       sig_Rinse_Completed;
  logic       sig_Spin_Completed;
  logic       sig_Time_Out;
  logic       cmd_Error;
  logic [2:0] phase;

  // controller side: drives commands and health, observes status
  modport master (
    output fill_Water_Operation, heat_Water_Operation, wash_Operation,
           rinse_Operation, spin_Operation, water_Supply_Ok, heater_Ok,
    input  sig_Full, sig_Temperature, sig_Wash_Completed, sig_Rinse_Completed,
           sig_Spin_Completed, sig_Time_Out, cmd_Error, phase
  );

  // plant side: the timer itself
  modport slave (
    input  fill_Water_Operation, heat_Water_Operation, wash_Operation,
           rinse_Operation, spin_Operation, water_Supply_Ok, heater_Ok,
    output sig_Full, sig_Temperature, sig_Wash_Completed, sig_Rinse_Completed,
           sig_Spin_Completed, sig_Time_Out, cmd_Error, phase
  );
endinterface
`default_nettype wire

// File: rtl/wash_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : wash_cycle_timer
// Description : Plant-side responder for the washing-machine controller.
//               Tracks the commanded phase, counts progress toward each
//               phase target and runs a watchdog over fill/heat.
// Revision    : 1.0 - initial release
// ============================================================================
module wash_cycle_timer #(
  parameter int unsigned FILL_CYCLES    = 8,
  parameter int unsigned HEAT_CYCLES    = 12,
  parameter int unsigned WASH_CYCLES    = 16,
  parameter int unsigned RINSE_CYCLES   = 10,
  parameter int unsigned SPIN_CYCLES    = 6,
  parameter int unsigned TIMEOUT_CYCLES = 20,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  wire logic          clock,
  input  wire logic          reset_n,
  wash_cycle_timer_if.slave  bus
);

  // Phase codes match the controller's state encoding for the same operation.
  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd2,
    PH_HEAT  = 3'd3,
    PH_WASH  = 3'd4,
    PH_RINSE = 3'd5,
    PH_SPIN  = 3'd6,
    PH_ERR   = 3'd7
  } phase_t;

  localparam logic [CNT_WIDTH-1:0] c_fill_target  = CNT_WIDTH'(FILL_CYCLES);
  localparam logic [CNT_WIDTH-1:0] c_heat_target  = CNT_WIDTH'(HEAT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] c_wash_target  = CNT_WIDTH'(WASH_CYCLES);
  localparam logic [CNT_WIDTH-1:0] c_rinse_target = CNT_WIDTH'(RINSE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] c_spin_target  = CNT_WIDTH'(SPIN_CYCLES);
  localparam logic [CNT_WIDTH-1:0] c_timeout      = CNT_WIDTH'(TIMEOUT_CYCLES);

  phase_t               r_phase;
  phase_t               w_phase_next;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] w_count_next;
  logic [CNT_WIDTH-1:0] r_wdog;
  logic [CNT_WIDTH-1:0] w_wdog_next;
  logic [CNT_WIDTH-1:0] w_target;
  logic                 w_advance;
  logic                 w_guarded;
  logic                 w_changed;
  logic [4:0]           w_cmd;
  logic                 w_full;
  logic                 w_temp;

  assign w_cmd = {bus.spin_Operation, bus.rinse_Operation, bus.wash_Operation,
                  bus.heat_Water_Operation, bus.fill_Water_Operation};

  // Phase register: follows the sampled commands every edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_phase <= PH_IDLE;
    else          r_phase <= w_phase_next;
  end

  // Next phase decode: none -> idle, one-hot -> that phase, several -> error.
  always_comb begin
    w_phase_next = PH_ERR;
    case (w_cmd)
      5'b00000: w_phase_next = PH_IDLE;
      5'b00001: w_phase_next = PH_FILL;
      5'b00010: w_phase_next = PH_HEAT;
      5'b00100: w_phase_next = PH_WASH;
      5'b01000: w_phase_next = PH_RINSE;
      5'b10000: w_phase_next = PH_SPIN;
      default:  w_phase_next = PH_ERR;
    endcase
  end

  // Per-phase target, progress enable and watchdog coverage for the current phase.
  always_comb begin
    w_target  = '0;
    w_advance = 1'b0;
    w_guarded = 1'b0;
    case (r_phase)
      PH_FILL:  begin w_target = c_fill_target;  w_advance = bus.water_Supply_Ok; w_guarded = 1'b1; end
      PH_HEAT:  begin w_target = c_heat_target;  w_advance = bus.heater_Ok;       w_guarded = 1'b1; end
      PH_WASH:  begin w_target = c_wash_target;  w_advance = 1'b1; end
      PH_RINSE: begin w_target = c_rinse_target; w_advance = 1'b1; end
      PH_SPIN:  begin w_target = c_spin_target;  w_advance = 1'b1; end
      default:  begin w_target = '0;             w_advance = 1'b0; end
    endcase
  end

  // Counter updates: any phase change restarts both counters from zero;
  // otherwise they climb and saturate at their limits.
  always_comb begin
    w_changed    = (w_phase_next != r_phase);
    w_count_next = r_count;
    w_wdog_next  = r_wdog;
    if (w_changed) begin
      w_count_next = '0;
      w_wdog_next  = '0;
    end else begin
      if (w_advance && (r_count != w_target)) w_count_next = r_count + 1'b1;
      if (w_guarded && (r_wdog != c_timeout)) w_wdog_next  = r_wdog + 1'b1;
    end
  end

  // Progress and watchdog counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_wdog  <= '0;
    end else begin
      r_count <= w_count_next;
      r_wdog  <= w_wdog_next;
    end
  end

  // Status outputs decoded purely from registered state.
  assign w_full = (r_phase == PH_FILL) && (r_count == c_fill_target);
  assign w_temp = (r_phase == PH_HEAT) && (r_count == c_heat_target);

  assign bus.sig_Full            = w_full;
  assign bus.sig_Temperature     = w_temp;
  assign bus.sig_Wash_Completed  = (r_phase == PH_WASH)  && (r_count == c_wash_target);
  assign bus.sig_Rinse_Completed = (r_phase == PH_RINSE) && (r_count == c_rinse_target);
  assign bus.sig_Spin_Completed  = (r_phase == PH_SPIN)  && (r_count == c_spin_target);
  // Completion takes priority over time-out within the same phase.
  assign bus.sig_Time_Out        = (r_wdog == c_timeout) &&
                                   (((r_phase == PH_FILL) && !w_full) ||
                                    ((r_phase == PH_HEAT) && !w_temp));
  assign bus.cmd_Error           = (r_phase == PH_ERR);
  assign bus.phase               = r_phase;

endmodule
`default_nettype wire
